// File: rtl/iob_reg.sv
// rtl/iob_reg.sv - data-hold register with async reset, sync clear and load enable
module iob_reg #(
  parameter int                DATA_W  = 32,
  parameter logic [DATA_W-1:0] RST_VAL = '0
) (
  input  logic              clk,
  input  logic              arst,
  input  logic              rst,
  input  logic              en,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      q <= RST_VAL;
    end else if (rst) begin
      q <= RST_VAL;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/iob_skid_buf_defs.vh
// rtl/iob_skid_buf_defs.vh - state encodings shared by the skid buffer FSM
localparam [1:0] ST_EMPTY = 2'd0;
localparam [1:0] ST_BUSY  = 2'd1;
localparam [1:0] ST_FULL  = 2'd2;

// File: rtl/iob_skid_buf.sv
// rtl/iob_skid_buf.sv - 2-entry valid/ready skid buffer, registered data and ready
// Optional stall counter enabled by macro IOB_SKID_BUF_STALL_CNT_EN.
module iob_skid_buf #(
  parameter int                DATA_W      = 32,
  parameter logic [DATA_W-1:0] RST_VAL     = '0,
  parameter int                STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   arst,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_W-1:0]      in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_W-1:0]      out_data
`ifdef IOB_SKID_BUF_STALL_CNT_EN
  ,
  output logic [STALL_CNT_W-1:0] stall_cnt
`endif
);

`include "iob_skid_buf_defs.vh"

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic              in_fire;
  logic              out_fire;
  logic              main_en;
  logic              skid_en;
  logic              main_from_skid;
  logic [DATA_W-1:0] main_d;
  logic [DATA_W-1:0] skid_q;

  // Both handshake outputs come from registered state; only rst gates in_ready.
  assign in_ready  = (state != ST_FULL) & ~rst;
  assign out_valid = (state != ST_EMPTY);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state <= ST_EMPTY;
    end else if (rst) begin
      state <= ST_EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    main_en        = 1'b0;
    skid_en        = 1'b0;
    main_from_skid = 1'b0;
    case (state)
      ST_EMPTY: begin
        if (in_fire) begin
          main_en   = 1'b1;
          state_nxt = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (in_fire && out_fire) begin
          main_en = 1'b1;
        end else if (in_fire) begin
          skid_en   = 1'b1;
          state_nxt = ST_FULL;
        end else if (out_fire) begin
          state_nxt = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (out_fire) begin
          main_en        = 1'b1;
          main_from_skid = 1'b1;
          state_nxt      = ST_BUSY;
        end
      end
      default: state_nxt = ST_EMPTY;
    endcase
  end

  assign main_d = main_from_skid ? skid_q : in_data;

  iob_reg #(
    .DATA_W (DATA_W),
    .RST_VAL(RST_VAL)
  ) u_main_reg (
    .clk (clk),
    .arst(arst),
    .rst (rst),
    .en  (main_en),
    .d   (main_d),
    .q   (out_data)
  );

  iob_reg #(
    .DATA_W (DATA_W),
    .RST_VAL(RST_VAL)
  ) u_skid_reg (
    .clk (clk),
    .arst(arst),
    .rst (rst),
    .en  (skid_en),
    .d   (in_data),
    .q   (skid_q)
  );

`ifdef IOB_SKID_BUF_STALL_CNT_EN
  // Saturating count of cycles the downstream held off a valid beat.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      stall_cnt <= '0;
    end else if (rst) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && !(&stall_cnt)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_iob_skid_buf.sv
// tb/tb_iob_skid_buf.sv - directed vector bench for iob_skid_buf
module tb_iob_skid_buf;

  localparam int         DW   = 8;
  localparam logic [7:0] RSTV = 8'h5A;

  logic         clk = 1'b0;
  logic         arst = 1'b1;
  logic         rst = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [DW-1:0] in_data = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [DW-1:0] out_data;
`ifdef IOB_SKID_BUF_STALL_CNT_EN
  logic [3:0]   stall_cnt;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  iob_skid_buf #(
    .DATA_W     (DW),
    .RST_VAL    (RSTV),
    .STALL_CNT_W(4)
  ) dut (
    .clk      (clk),
    .arst     (arst),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data)
`ifdef IOB_SKID_BUF_STALL_CNT_EN
    ,
    .stall_cnt(stall_cnt)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic       rst;
    logic       iv;
    logic [7:0] id;
    logic       ordy;
    logic       e_irdy;
    logic       e_ov;
    logic [7:0] e_od;
  } vec_t;

  vec_t vecs[16];

  initial begin
    // rst, in_valid, in_data, out_ready | in_ready, out_valid, out_data (before the edge)
    vecs[0]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h5A};
    vecs[1]  = '{1'b0, 1'b1, 8'h0A, 1'b0, 1'b1, 1'b0, 8'h5A};
    vecs[2]  = '{1'b0, 1'b1, 8'h0B, 1'b0, 1'b1, 1'b1, 8'h0A};
    vecs[3]  = '{1'b0, 1'b1, 8'h0C, 1'b0, 1'b0, 1'b1, 8'h0A};
    vecs[4]  = '{1'b0, 1'b1, 8'h0C, 1'b0, 1'b0, 1'b1, 8'h0A};
    vecs[5]  = '{1'b0, 1'b1, 8'h0C, 1'b1, 1'b0, 1'b1, 8'h0A};
    vecs[6]  = '{1'b0, 1'b1, 8'h0C, 1'b1, 1'b1, 1'b1, 8'h0B};
    vecs[7]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h0C};
    vecs[8]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h0C};
    vecs[9]  = '{1'b0, 1'b1, 8'h05, 1'b0, 1'b1, 1'b0, 8'h0C};
    vecs[10] = '{1'b0, 1'b1, 8'h06, 1'b0, 1'b1, 1'b1, 8'h05};
    vecs[11] = '{1'b1, 1'b1, 8'h99, 1'b1, 1'b0, 1'b1, 8'h05};
    vecs[12] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h5A};
    vecs[13] = '{1'b0, 1'b1, 8'h07, 1'b1, 1'b1, 1'b0, 8'h5A};
    vecs[14] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h07};
    vecs[15] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h07};

    repeat (2) @(negedge clk);
`ifdef IOB_SKID_BUF_STALL_CNT_EN
    check("reset_stall_cnt", 32'(stall_cnt), 32'h0);
`endif
    arst = 1'b0;

    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      rst       = vecs[i].rst;
      in_valid  = vecs[i].iv;
      in_data   = vecs[i].id;
      out_ready = vecs[i].ordy;
      #1;
      check($sformatf("vec%0d_in_ready", i),  32'(in_ready),  32'(vecs[i].e_irdy));
      check($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].e_ov));
      check($sformatf("vec%0d_out_data", i),  32'(out_data),  32'(vecs[i].e_od));
    end

    // back-to-back streaming of 0x1..0x10 with out_ready held high
    for (int c = 0; c < 18; c++) begin
      @(negedge clk);
      rst       = 1'b0;
      out_ready = 1'b1;
      in_valid  = (c < 16);
      in_data   = 8'(c + 1);
      #1;
      if (c < 16) check($sformatf("stream%0d_in_ready", c), 32'(in_ready), 32'h1);
      if (c >= 1 && c <= 16) begin
        check($sformatf("stream%0d_out_valid", c), 32'(out_valid), 32'h1);
        check($sformatf("stream%0d_out_data", c),  32'(out_data),  32'(c));
      end else begin
        check($sformatf("stream%0d_out_valid", c), 32'(out_valid), 32'h0);
      end
    end

`ifdef IOB_SKID_BUF_STALL_CNT_EN
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    arst      = 1'b1;
    #1;
    check("stall_arst_cnt", 32'(stall_cnt), 32'h0);
    check("stall_arst_ov",  32'(out_valid), 32'h0);
    arst = 1'b0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 8'h33;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check("stall_start_cnt", 32'(stall_cnt), 32'h0);
    check("stall_start_ov",  32'(out_valid), 32'h1);
    repeat (5) @(negedge clk);
    #1;
    check("stall_cnt_5", 32'(stall_cnt), 32'h5);
    repeat (15) @(negedge clk);
    #1;
    check("stall_cnt_sat", 32'(stall_cnt), 32'hF);
    repeat (2) @(negedge clk);
    #1;
    check("stall_cnt_hold", 32'(stall_cnt), 32'hF);
    check("stall_data_stable", 32'(out_data), 32'h33);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
